// File: rtl/fp16_pkg.sv
// Shared definitions for the FP16 -> int16 converter: IEEE half field layout,
// FSM state encoding and saturation constants.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int MANT_W  = FRAC_W + 1;
  localparam int FP_W    = 1 + EXP_W + FRAC_W;
  localparam int BIAS    = 15;
  localparam int EXP_MAX = 31;

  localparam logic [15:0] SAT_POS = 16'h7FFF;
  localparam logic [15:0] SAT_NEG = 16'h8000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fp16_unpack.sv
// Combinational classification of an IEEE half operand into zero / subnormal /
// inf / nan / normal, plus unbiased exponent and mantissa with hidden bit.
module fp16_unpack
  import fp16_pkg::*;
(
  input  logic                    fp_word_valid_unused_tie,
  input  logic [FP_W-1:0]         fp,
  output logic                    sign,
  output logic                    is_zero,
  output logic                    is_sub,
  output logic                    is_inf,
  output logic                    is_nan,
  output logic                    is_norm,
  output logic signed [EXP_W:0]   e,
  output logic [MANT_W-1:0]       mant
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;
  logic              exp_zero;
  logic              exp_max;
  logic              frac_zero;

  assign sign      = fp[FP_W-1];
  assign exp_f     = fp[FRAC_W +: EXP_W];
  assign frac_f    = fp[FRAC_W-1:0];

  assign exp_zero  = (exp_f == '0);
  assign exp_max   = (exp_f == EXP_W'(EXP_MAX));
  assign frac_zero = (frac_f == '0);

  assign is_zero   = exp_zero & frac_zero;
  assign is_sub    = exp_zero & ~frac_zero;
  assign is_inf    = exp_max & frac_zero;
  assign is_nan    = exp_max & ~frac_zero;
  assign is_norm   = ~exp_zero & ~exp_max & fp_word_valid_unused_tie;

  // Two's-complement subtract; the 6-bit result covers -15..16.
  assign e    = $signed({1'b0, exp_f} - (EXP_W+1)'(BIAS));
  assign mant = {1'b1, frac_f};

endmodule

// File: rtl/fp16_to_int.sv
// FP16 -> signed INT_W converter with a one-bit-per-cycle shifter.
// Optional FP16_CVT_ROUND_EN: round-to-nearest-even instead of truncation.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for an operand; in_ready high
// ST_SHIFT | aligning mantissa, one bit per cycle until count is 0
// ST_DONE  | result registered; out_valid high until consumed
module fp16_to_int
  import fp16_pkg::*;
#(
  parameter int INT_W = 16
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_fp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_int,
  output logic             out_ovf,
  output logic             out_inexact
);

  localparam int SR_W = INT_W + MANT_W;
  localparam logic signed [EXP_W:0] E_TEN = (EXP_W+1)'(FRAC_W);
  localparam logic signed [EXP_W:0] E_SAT = (EXP_W+1)'(INT_W - 1);
  localparam logic [INT_W-1:0] SAT_P = INT_W'(SAT_POS);
  localparam logic [INT_W-1:0] SAT_N = INT_W'(SAT_NEG);

  state_t            state, state_nxt;
  logic [SR_W-1:0]   sr, sr_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic              left_q, left_nxt;
  logic              guard, guard_nxt;
  logic              sticky, sticky_nxt;
  logic              sign_q, sign_nxt;
  logic [INT_W-1:0]  int_q, int_nxt;
  logic              ovf_q, ovf_nxt;
  logic              inex_q, inex_nxt;

  logic              u_sign, u_zero, u_sub, u_inf, u_nan, u_norm;
  logic signed [EXP_W:0] u_e;
  logic [MANT_W-1:0] u_mant;

  logic [INT_W-1:0]  fin_int;
  logic              fin_ovf;

  fp16_unpack u_unpack (
    .fp_word_valid_unused_tie (1'b1),
    .fp      (in_fp),
    .sign    (u_sign),
    .is_zero (u_zero),
    .is_sub  (u_sub),
    .is_inf  (u_inf),
    .is_nan  (u_nan),
    .is_norm (u_norm),
    .e       (u_e),
    .mant    (u_mant)
  );

  assign in_ready    = (state == ST_IDLE);
  assign out_valid   = (state == ST_DONE);
  assign out_int     = int_q;
  assign out_ovf     = ovf_q;
  assign out_inexact = inex_q;

`ifdef FP16_CVT_ROUND_EN
  logic             rnd_up;
  logic [INT_W:0]   mag_rnd;

  // Nearest-even: round up above half, or at exactly half when the LSB is odd.
  assign rnd_up  = guard & (sticky | sr[0]);
  assign mag_rnd = {1'b0, sr[INT_W-1:0]} + {{INT_W{1'b0}}, rnd_up};

  always_comb begin
    fin_ovf = mag_rnd[INT_W] | mag_rnd[INT_W-1];
    fin_int = sign_q ? INT_W'(-mag_rnd) : mag_rnd[INT_W-1:0];
    if (fin_ovf) fin_int = sign_q ? SAT_N : SAT_P;
  end
`else
  always_comb begin
    fin_ovf = 1'b0;
    fin_int = sign_q ? -sr[INT_W-1:0] : sr[INT_W-1:0];
  end
`endif

  always_comb begin
    state_nxt  = state;
    sr_nxt     = sr;
    cnt_nxt    = cnt;
    left_nxt   = left_q;
    guard_nxt  = guard;
    sticky_nxt = sticky;
    sign_nxt   = sign_q;
    int_nxt    = int_q;
    ovf_nxt    = ovf_q;
    inex_nxt   = inex_q;

    case (state)
      ST_IDLE: begin
        if (in_valid) begin
          sign_nxt   = u_sign;
          sr_nxt     = SR_W'(u_mant);
          guard_nxt  = 1'b0;
          sticky_nxt = 1'b0;
          left_nxt   = (u_e > E_TEN);
          cnt_nxt    = (u_e > E_TEN) ? 5'(u_e - E_TEN) : 5'(E_TEN - u_e);
          int_nxt    = '0;
          ovf_nxt    = 1'b0;
          inex_nxt   = 1'b0;
          state_nxt  = ST_DONE;
          if (u_zero || u_sub) begin
            inex_nxt = u_sub;
          end else if (u_nan) begin
            ovf_nxt = 1'b1;
          end else if (u_inf) begin
            int_nxt = u_sign ? SAT_N : SAT_P;
            ovf_nxt = 1'b1;
          end else if (u_e >= E_SAT) begin
            // -2^15 exactly is representable; everything else here saturates.
            int_nxt = u_sign ? SAT_N : SAT_P;
            ovf_nxt = !(u_sign && (u_e == E_SAT) && (u_mant[FRAC_W-1:0] == '0));
          end
`ifndef FP16_CVT_ROUND_EN
          else if (u_e[EXP_W]) begin
            inex_nxt = 1'b1;
          end
`endif
          else if (u_norm) begin
            state_nxt = ST_SHIFT;
          end
        end
      end

      ST_SHIFT: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - 5'd1;
          if (left_q) begin
            sr_nxt = sr << 1;
          end else begin
            sr_nxt     = sr >> 1;
            guard_nxt  = sr[0];
            sticky_nxt = sticky | guard;
          end
        end else begin
          int_nxt   = fin_int;
          ovf_nxt   = fin_ovf;
          inex_nxt  = guard | sticky;
          state_nxt = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) state_nxt = ST_IDLE;
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      sr     <= '0;
      cnt    <= '0;
      left_q <= 1'b0;
      guard  <= 1'b0;
      sticky <= 1'b0;
      sign_q <= 1'b0;
      int_q  <= '0;
      ovf_q  <= 1'b0;
      inex_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sr     <= sr_nxt;
      cnt    <= cnt_nxt;
      left_q <= left_nxt;
      guard  <= guard_nxt;
      sticky <= sticky_nxt;
      sign_q <= sign_nxt;
      int_q  <= int_nxt;
      ovf_q  <= ovf_nxt;
      inex_q <= inex_nxt;
    end
  end

endmodule

// File: tb/tb_fp16_to_int.sv
// Self-checking bench for fp16_to_int: directed corner values plus random
// operands against an arithmetic reference model (honours FP16_CVT_ROUND_EN).
module tb_fp16_to_int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_fp = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_int;
  logic        out_ovf;
  logic        out_inexact;

  int checks = 0;
  int failures = 0;

  fp16_to_int #(.INT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_fp       (in_fp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_int     (out_int),
    .out_ovf     (out_ovf),
    .out_inexact (out_inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: value = (1024+frac) * 2^(exp-25), converted with integer division.
  function automatic void ref_conv(input logic [15:0] fp, output logic [15:0] r,
                                   output logic ovf, output logic inex, output int lat);
    int ex, fr, sg;
    longint mant, q, rem, d, v;
    sg = int'(fp[15]);
    ex = int'(fp[14:10]);
    fr = int'(fp[9:0]);
    r = '0; ovf = 1'b0; inex = 1'b0; lat = 0;
    if (ex == 0) begin
      inex = (fr != 0);
      return;
    end
    if (ex == 31) begin
      ovf = 1'b1;
      if (fr == 0) r = (sg != 0) ? 16'h8000 : 16'h7FFF;
      return;
    end
    mant = 1024 + fr;
    rem = 0;
    if (ex >= 25) begin
      q = mant << (ex - 25);
    end else begin
      d = longint'(1) << (25 - ex);
      q = mant / d;
      rem = mant % d;
`ifdef FP16_CVT_ROUND_EN
      if ((2 * rem > d) || ((2 * rem == d) && q[0])) q = q + 1;
`endif
    end
    inex = (rem != 0);
    v = (sg != 0) ? -q : q;
    if (v > 32767) begin
      r = 16'h7FFF; ovf = 1'b1; inex = 1'b0;
    end else if (v < -32768) begin
      r = 16'h8000; ovf = 1'b1; inex = 1'b0;
    end else begin
      r = v[15:0];
    end
    if (ex >= 30) lat = 0;
`ifndef FP16_CVT_ROUND_EN
    else if (ex < 15) lat = 0;
`endif
    else lat = ((ex > 25) ? ex - 25 : 25 - ex) + 1;
  endfunction

  // Drives one operand with out_ready high; returns the first result seen, the
  // number of edges after accept until out_valid (-1 on timeout), and in_ready
  // just after the consume edge.
  task automatic run_op(input logic [15:0] fp, output logic [15:0] r, output logic ovf,
                        output logic inex, output int lat, output logic ir_after,
                        output logic ov_after);
    in_fp = fp;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_fp = 16'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) lat = -1;
    r = out_int;
    ovf = out_ovf;
    inex = out_inexact;
    @(posedge clk);
    #1;
    ir_after = in_ready;
    ov_after = out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_int !== 16'h0000) begin failures++; $display("FAIL reset_out_int got=%h exp=0000", out_int); end
    checks++; if (out_ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
    checks++; if (out_inexact !== 1'b0) begin failures++; $display("FAIL reset_inexact got=%b exp=0", out_inexact); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] vin [13];
    logic [15:0] vres [13];
    logic        vovf [13];
    logic        vinex [13];
    logic [15:0] r;
    logic        ovf, inex, ira, ova;
    int          lat;
    vin  = '{16'h3C00, 16'h5640, 16'hC500, 16'h7C00, 16'h7800, 16'hF800, 16'h7E00,
             16'h3E00, 16'h3800, 16'h3A00, 16'hFC00, 16'h0001, 16'h8000};
`ifdef FP16_CVT_ROUND_EN
    vres = '{16'h0001, 16'h0064, 16'hFFFB, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000,
             16'h0002, 16'h0000, 16'h0001, 16'h8000, 16'h0000, 16'h0000};
`else
    vres = '{16'h0001, 16'h0064, 16'hFFFB, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000,
             16'h0001, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000};
`endif
    vovf  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vinex = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      run_op(vin[i], r, ovf, inex, lat, ira, ova);
      checks++; if (lat < 0) begin failures++; $display("FAIL dir_timeout in=%h no out_valid within 40 edges", vin[i]); end
      checks++; if (r !== vres[i]) begin failures++; $display("FAIL dir_int in=%h got=%h exp=%h", vin[i], r, vres[i]); end
      checks++; if (ovf !== vovf[i]) begin failures++; $display("FAIL dir_ovf in=%h got=%b exp=%b", vin[i], ovf, vovf[i]); end
      checks++; if (inex !== vinex[i]) begin failures++; $display("FAIL dir_inexact in=%h got=%b exp=%b", vin[i], inex, vinex[i]); end
      if (i == 0) begin
        checks++; if (lat !== 11) begin failures++; $display("FAIL dir_latency_1p0 got=%0d exp=11", lat); end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] fp, r, er;
    logic        ovf, inex, eovf, einex, ira, ova;
    int          lat, elat;
    for (int i = 0; i < 60; i++) begin
      fp = {1'($urandom), 5'($urandom_range(0, 31)), 10'($urandom)};
      if (i % 4 == 0) fp[9:0] = '0;
      ref_conv(fp, er, eovf, einex, elat);
      run_op(fp, r, ovf, inex, lat, ira, ova);
      checks++; if (r !== er) begin failures++; $display("FAIL rnd_int in=%h got=%h exp=%h", fp, r, er); end
      checks++; if (ovf !== eovf) begin failures++; $display("FAIL rnd_ovf in=%h got=%b exp=%b", fp, ovf, eovf); end
      checks++; if (inex !== einex) begin failures++; $display("FAIL rnd_inexact in=%h got=%b exp=%b", fp, inex, einex); end
      checks++;
      if ((elat == 0) ? (lat < 0 || lat > 1) : (lat != elat)) begin
        failures++; $display("FAIL rnd_latency in=%h got=%0d exp=%0d", fp, lat, elat);
      end
    end
  endtask

  task automatic test_hold();
    int lat;
    in_fp = 16'h5640;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_fp = 16'h0000;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++; if (!out_valid) begin failures++; $display("FAIL hold_timeout out_valid never rose"); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", c, out_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      checks++; if (out_int !== 16'h0064) begin failures++; $display("FAIL hold_int cyc=%0d got=%h exp=0064", c, out_int); end
      checks++; if ({out_ovf, out_inexact} !== 2'b00) begin failures++; $display("FAIL hold_flags cyc=%0d got=%b exp=00", c, {out_ovf, out_inexact}); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL hold_consume got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int seen;
    in_fp = 16'h3C00;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_busy in_ready got=%b exp=0", in_ready); end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_rst_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_int !== 16'h0000) begin failures++; $display("FAIL mid_rst_out_int got=%h exp=0000", out_int); end
    checks++; if ({out_ovf, out_inexact} !== 2'b00) begin failures++; $display("FAIL mid_rst_flags got=%b exp=00", {out_ovf, out_inexact}); end
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL mid_rst_no_result got=%0d valid cycles exp=0", seen); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] fp, r, er;
    logic        ovf, inex, eovf, einex, ira, ova;
    int          lat, elat;
    for (int i = 0; i < 6; i++) begin
      fp = {1'($urandom), 5'($urandom_range(12, 28)), 10'($urandom)};
      ref_conv(fp, er, eovf, einex, elat);
      run_op(fp, r, ovf, inex, lat, ira, ova);
      checks++; if (r !== er) begin failures++; $display("FAIL b2b_int in=%h got=%h exp=%h", fp, r, er); end
      checks++; if (ira !== 1'b1) begin failures++; $display("FAIL b2b_in_ready_after_consume got=%b exp=1", ira); end
      checks++; if (ova !== 1'b0) begin failures++; $display("FAIL b2b_out_valid_after_consume got=%b exp=0", ova); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp16_to_int.md
FP16_TO_INT -- requirements
Module: fp16_to_int

Interface
REQ-001 Parameter: INT_W, 16, signed integer result width; only 16 is supported.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  in_fp is valid this cycle.
REQ-005 Port: in_ready  output  1  block can accept an operand; high only in IDLE.
REQ-006 Port: in_fp  input  16  IEEE half operand {sign, exp[4:0], frac[9:0]}.
REQ-007 Port: out_valid  output  1  result valid; high only in DONE.
REQ-008 Port: out_ready  input  1  consumer accepts the result.
REQ-009 Port: out_int  output  INT_W  two's-complement integer result.
REQ-010 Port: out_ovf  output  1  result saturated, or operand was NaN.
REQ-011 Port: out_inexact  output  1  nonzero fraction bits were discarded.

Function
REQ-012 Handshake: operand accepted on an edge with in_valid && in_ready; result consumed on an edge with out_valid && out_ready.
REQ-013 Holding: out_int, out_ovf and out_inexact stay stable while out_valid && !out_ready; in_fp is sampled only at accept.
REQ-014 FSM states: IDLE, SHIFT, DONE; IDLE->SHIFT for normal in-range operands, IDLE->DONE for special cases, SHIFT->DONE when the count reaches 0, DONE->IDLE on consume.
REQ-015 Decode: e = exp-15; mant = {1,frac} (11 bits), held in a shift register at least INT_W+11 bits wide with a sticky bit.
REQ-016 exp==0 (zero or subnormal): result 0, ovf 0, inexact = (frac!=0), direct to DONE.
REQ-017 exp==31: Inf gives 0x7FFF (+) or 0x8000 (-) with ovf 1; NaN gives 0 with ovf 1; direct to DONE.
REQ-018 e<0 (exp<15): result 0, ovf 0, inexact 1, direct to DONE; this path is used when FP16_CVT_ROUND_EN is undefined.
REQ-019 e>=INT_W-1: saturate to 0x7FFF or 0x8000 with ovf 1, direct to DONE; exception: sign=1, e==15, frac==0 yields 0x8000 with ovf 0.
REQ-020 0<=e<=14: count n = |10-e|; one bit shift per SHIFT cycle (right if e<10, left if e>10); right-shifted-out bits OR into sticky.
REQ-021 SHIFT with count 0: finalize magnitude, apply optional rounding, negate if sign, set inexact = sticky, register outputs, go to DONE.
REQ-022 Latency: accept at edge k gives out_valid high after edge k+n+1 (normal) or k+1 (special); back-to-back accept is allowed on the edge after consume.
REQ-023 Default conversion truncates toward zero.

Reset
REQ-024 rst gives state IDLE, in_ready 1, out_valid 0, out_int 0, out_ovf 0, out_inexact 0, count 0, sticky 0.
REQ-025 rst asserted in SHIFT or DONE aborts the operation with no output handshake; rst has priority over all handshakes.

Configuration
REQ-026 FP16_CVT_ROUND_EN defined: round to nearest even on guard/sticky after right shifts; e<0 operands also take the SHIFT path so 0.5 gives 0 and 0.75 gives 1.
REQ-027 With FP16_CVT_ROUND_EN defined: a rounding carry past INT_W-1 magnitude saturates with ovf 1.
REQ-028 FP16_CVT_ROUND_EN undefined: truncation only; the rounding logic is absent.

Structure
REQ-029 A shared package fp16_pkg holds the field widths (EXP_W=5, FRAC_W=10), BIAS=15, EXP_MAX=31, the FSM state typedef, and the saturation constants.
REQ-030 One sub-module, fp16_unpack: combinational classification (zero, subnormal, inf, nan, normal) plus e and mant; the FSM and shifter stay in the top module.

Verification
REQ-031 0x3C00 (1.0), out_ready=1 -> out_int 0x0001, ovf 0, inexact 0, out_valid after edge k+11.
REQ-032 0x5640 (100.0) -> 0x0064; 0xC500 (-5.0) -> 0xFFFB; both exact.
REQ-033 0x7C00 -> 0x7FFF ovf 1; 0x7800 (+32768) -> 0x7FFF ovf 1; 0xF800 (-32768) -> 0x8000 ovf 0; 0x7E00 (NaN) -> 0x0000 ovf 1.
REQ-034 0x3E00 (1.5) -> 0x0001 inexact 1 without the macro, 0x0002 with it; 0x3800 (0.5) -> 0x0000 inexact 1 in both builds.
REQ-035 out_ready held low for 5 cycles -> outputs stable and in_ready 0 throughout; rst pulsed mid-SHIFT -> IDLE on the next edge with all outputs 0.
